sigma_mc_ctrl_fsm: RTL and testbench
====================================

// Module: sigma_mc_ctrl_fsm
// PURPOSE
// - Next-generation multicycle main control FSM for SigmaCore RV32I: drives datapath enables/muxes from IR opcode.
// - Extends the 8-state LW/SW/R/I flow with load read/write-back, LUI execute, BEQ-class branch, illegal-opcode trap.
// - Adds a mem_req/mem_ready wait-state handshake with a parametrised timeout.
// - Sits between the IR and the datapath; feeds the ALU control unit (alu_op) and sign extender (imm_type).
// PARAMETERS
// - TIMEOUT_CYCLES  16  consecutive unanswered wait cycles before FAULT; 0 = timeout disabled
// - TIMEOUT_W       $clog2(TIMEOUT_CYCLES+1)  wait-counter width
// - PERF_W          32  perf-counter width; used only with SIGMA_PERF_CNT_EN
// PORTS
// - clk           in   1        clock, rising edge
// - rst           in   1        synchronous, active-high reset
// - opcode        in   7        IR[6:0], stable from DECODE onward
// - mem_ready     in   1        memory done/accepted this cycle
// - branch_taken  in   1        datapath comparator result for current branch
// - mem_req       out  1        memory access request
// - mem_we        out  1        memory write
// - adr_src       out  1        0 = PC, 1 = ALUOut
// - ir_write      out  1        latch IR/oldPC
// - pc_write      out  1        PC <= result
// - reg_write     out  1        register-file write
// - alu_src_a     out  2        00 PC, 01 oldPC, 10 rs1
// - alu_src_b     out  2        00 rs2, 01 imm, 10 const 4
// - alu_op        out  2        ALU_OP_TYPE_* (adds ALU_OP_TYPE_BR = 2'b11)
// - result_src    out  2        00 ALUOut, 01 mem rdata, 10 ALU result
// - imm_type      out  3        IMM_TYPE_* from opcode
// - fault         out  1        sticky trap indicator
// - state_o       out  4        current state (debug)
// BEHAVIOUR
// - Reset: state = S_FETCH, wait counter = 0, fault = 0. All enables (mem_req, mem_we, ir_write, pc_write, reg_write) = 0 while rst = 1; mux selects = 0.
// - Outputs are combinational from state. ir_write/pc_write in FETCH are gated by mem_ready; pc_write in BRANCH is gated by branch_taken.
// - imm_type in every state: LOAD/IMM -> I, STORE -> S, BRANCH -> B, LUI -> U, else NONE.
// - FETCH(0): mem_req, adr_src 0, a=PC, b=4, alu_op LSU, result_src 10. On mem_ready: ir_write, pc_write, -> DECODE; else hold.
// - DECODE(1): a=oldPC, b=imm, alu_op LSU (branch target -> ALUOut).
//   - LOAD/STORE -> MEM_ADDR; RTYPE -> EXEC_R; IMM -> EXEC_I; LUI -> EXEC_LUI; BRANCH -> BRANCH; other -> FAULT.
// - MEM_ADDR(2): a=rs1, b=imm, alu_op LSU. LOAD -> MEM_READ, STORE -> MEM_WRITE.
// - MEM_WRITE(3): mem_req, mem_we, adr_src 1. On mem_ready -> FETCH.
// - EXEC_R(4): a=rs1, b=rs2, alu_op R_I -> WB_R.
// - WB_R(5): reg_write, result_src 00 -> FETCH.
// - EXEC_I(6): a=rs1, b=imm, alu_op R_I -> WB_I.
// - WB_I(7): reg_write, result_src 00 -> FETCH.
// - MEM_READ(8): mem_req, adr_src 1. On mem_ready -> WB_MEM.
// - WB_MEM(9): reg_write, result_src 01 -> FETCH.
// - BRANCH(10): a=rs1, b=rs2, alu_op BR, result_src 00, pc_write = branch_taken -> FETCH.
// - EXEC_LUI(11): b=imm, alu_op LUI -> WB_I.
// - FAULT(15): all enables 0, fault = 1. Exits only via rst.
// - Wait counter: increments each cycle in FETCH/MEM_READ/MEM_WRITE with mem_req & !mem_ready; clears on mem_ready or state change.
//   - TIMEOUT_CYCLES > 0: the TIMEOUT_CYCLES-th consecutive unanswered cycle moves to FAULT next edge.
//   - mem_ready on that same cycle wins; normal transition is taken.
// - Latencies at zero wait: R/I/LUI 4 cycles, load 5, store 4, branch 3.
// - rst mid-instruction: abandons the access, returns to FETCH next edge, and clears fault.
// CONFIGURATION
// - SIGMA_PERF_CNT_EN defined: adds outputs cycle_cnt_o[PERF_W] and instret_o[PERF_W]; both reset to 0.
//   - cycle_cnt_o increments every cycle not in FAULT.
//   - instret_o increments on each transition into FETCH from a terminal state (MEM_WRITE, WB_R, WB_I, WB_MEM, BRANCH).
//   - Both wrap modulo 2^PERF_W.
// - Not defined: ports and counters are absent; FSM behaviour is identical.
// STRUCTURE
// - sigma_pkg gains S_MEM_READ = 8, S_WB_MEM = 9, S_BRANCH = 10, S_EXEC_LUI = 11, S_FAULT = 15, ALU_OP_TYPE_BR = 2'b11, OPCODE_JAL/JALR reserved, and ALU_SRC_A_*/ALU_SRC_B_*/RESULT_SRC_* localparams.
// - Sub-module sigma_mem_wait_timer: wait counter plus timeout compare.
// - Next-state logic and output decode stay in this module.
// TESTING
// - ADD (0110011), mem_ready=1 -> states 0,1,4,5,0; reg_write only in cycle 4 of the sequence.
// - LW (0000011), MEM_READ mem_ready low for 3 cycles -> mem_req/adr_src=1 held 4 cycles; then WB_MEM with result_src=01, reg_write.
// - BEQ (1100011): branch_taken=1 -> pc_write=1 in BRANCH, back to FETCH; branch_taken=0 -> pc_write=0; imm_type=3'b011.
// - opcode 7'b1111111 -> FAULT after DECODE, fault=1, enables 0 for 20 cycles; rst -> FETCH, fault=0.
// - TIMEOUT_CYCLES=4, mem_ready stuck 0 in FETCH -> FAULT on 5th edge; mem_ready on 4th cycle -> DECODE instead.
// - SIGMA_PERF_CNT_EN: ADD,ADDI,SW,BEQ at zero wait -> instret_o=4, cycle_cnt_o=15; PERF_W=4 wraps 15 -> 0.

Source files
------------

// File: rtl/sigma_pkg.sv
// sigma_pkg: shared encodings for the SigmaCore RV32I multicycle controller.
// Contents: FSM state encoding, RV32I major opcodes, ALU-op classes,
// immediate-format codes, datapath mux-select codes and an opcode-to-
// immediate-format helper. No ports.
package sigma_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_WRITE = 4'd3,
    S_EXEC_R    = 4'd4,
    S_WB_R      = 4'd5,
    S_EXEC_I    = 4'd6,
    S_WB_I      = 4'd7,
    S_MEM_READ  = 4'd8,
    S_WB_MEM    = 4'd9,
    S_BRANCH    = 4'd10,
    S_EXEC_LUI  = 4'd11,
    S_FAULT     = 4'd15
  } state_t;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPCODE_IMM    = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  // Reserved for a later jump extension; currently decoded as illegal.
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

  localparam logic [1:0] ALU_OP_TYPE_LSU = 2'b00;
  localparam logic [1:0] ALU_OP_TYPE_LUI = 2'b01;
  localparam logic [1:0] ALU_OP_TYPE_R_I = 2'b10;
  localparam logic [1:0] ALU_OP_TYPE_BR  = 2'b11;

  localparam logic [2:0] IMM_TYPE_NONE = 3'b000;
  localparam logic [2:0] IMM_TYPE_I    = 3'b001;
  localparam logic [2:0] IMM_TYPE_S    = 3'b010;
  localparam logic [2:0] IMM_TYPE_B    = 3'b011;
  localparam logic [2:0] IMM_TYPE_U    = 3'b100;

  localparam logic [1:0] ALU_SRC_A_PC    = 2'b00;
  localparam logic [1:0] ALU_SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] ALU_SRC_A_RS1   = 2'b10;

  localparam logic [1:0] ALU_SRC_B_RS2  = 2'b00;
  localparam logic [1:0] ALU_SRC_B_IMM  = 2'b01;
  localparam logic [1:0] ALU_SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RESULT_SRC_ALUOUT = 2'b00;
  localparam logic [1:0] RESULT_SRC_RDATA  = 2'b01;
  localparam logic [1:0] RESULT_SRC_ALU    = 2'b10;

  function automatic logic [2:0] imm_type_of(input logic [6:0] opc);
    case (opc)
      OPCODE_LOAD, OPCODE_IMM: imm_type_of = IMM_TYPE_I;
      OPCODE_STORE:            imm_type_of = IMM_TYPE_S;
      OPCODE_BRANCH:           imm_type_of = IMM_TYPE_B;
      OPCODE_LUI:              imm_type_of = IMM_TYPE_U;
      default:                 imm_type_of = IMM_TYPE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sigma_mem_wait_timer.sv
// sigma_mem_wait_timer: counts consecutive unanswered memory-wait cycles and
// flags the cycle on which the limit is reached.
// Ports:
//   clk     in  clock, rising edge
//   rst     in  synchronous active-high reset
//   stall   in  request pending and memory not ready this cycle
//   timeout out this is the TIMEOUT_CYCLES-th consecutive stalled cycle
// TIMEOUT_CYCLES = 0 disables the timeout (counter saturates, never fires).
module sigma_mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TIMEOUT_W      = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  output logic timeout
);

  logic [TIMEOUT_W-1:0] count_q;

  // Any non-stalled cycle (memory answered, or no request because the FSM
  // moved on) restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (!stall || timeout) begin
      count_q <= '0;
    end else if (count_q != '1) begin
      count_q <= count_q + 1'b1;
    end
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout_on
      localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
      assign timeout = stall && (count_q == LAST);
    end else begin : g_timeout_off
      assign timeout = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/sigma_mc_ctrl_fsm.sv
// sigma_mc_ctrl_fsm: multicycle main control FSM for SigmaCore RV32I.
// Decodes the IR opcode into datapath enables and mux selects, handles the
// mem_req/mem_ready handshake with a wait-cycle timeout, and traps illegal
// opcodes into a sticky FAULT state left only through rst.
// Ports:
//   clk, rst (sync, active high); opcode = IR[6:0]; mem_ready; branch_taken
//   mem_req, mem_we, adr_src, ir_write, pc_write, reg_write  enables/selects
//   alu_src_a, alu_src_b, alu_op, result_src, imm_type        datapath controls
//   fault (sticky trap), state_o (debug)
// Optional macro SIGMA_PERF_CNT_EN adds cycle_cnt_o and instret_o counters.
//
// state       | meaning
// ------------+---------------------------------------------
// FETCH    0  | read instruction at PC, PC <= PC+4 on ready
// DECODE   1  | branch target into ALUOut, dispatch on opcode
// MEM_ADDR 2  | rs1 + imm effective address
// MEM_WRITE 3 | store access, wait for ready
// EXEC_R   4  | rs1 op rs2
// WB_R     5  | write R-type result
// EXEC_I   6  | rs1 op imm
// WB_I     7  | write I-type / LUI result
// MEM_READ 8  | load access, wait for ready
// WB_MEM   9  | write load data
// BRANCH  10  | compare rs1/rs2, PC <= target if taken
// EXEC_LUI 11 | pass U-immediate through ALU
// FAULT   15  | illegal opcode or memory timeout, sticky
module sigma_mc_ctrl_fsm
  import sigma_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TIMEOUT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
`ifdef SIGMA_PERF_CNT_EN
  ,
  parameter int PERF_W         = 32
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  result_src,
  output logic [2:0]  imm_type,
  output logic        fault,
  output logic [3:0]  state_o
`ifdef SIGMA_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] cycle_cnt_o,
  output logic [PERF_W-1:0] instret_o
`endif
);

  state_t     state_q, state_d;
  logic       req_r, we_r, adr_r, irw_r, pcw_r, rw_r, flt_r;
  logic [1:0] a_r, b_r, op_r, res_r;
  logic       stall, timeout;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // req_r is only raised in the three wait-capable states, so this is the
  // "request outstanding, not answered" condition the timer needs.
  assign stall = req_r && !mem_ready;

  sigma_mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_W     (TIMEOUT_W)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .stall  (stall),
    .timeout(timeout)
  );

  always_comb begin
    state_d = state_q;
    req_r   = 1'b0;
    we_r    = 1'b0;
    adr_r   = 1'b0;
    irw_r   = 1'b0;
    pcw_r   = 1'b0;
    rw_r    = 1'b0;
    flt_r   = 1'b0;
    a_r     = ALU_SRC_A_PC;
    b_r     = ALU_SRC_B_RS2;
    op_r    = ALU_OP_TYPE_LSU;
    res_r   = RESULT_SRC_ALUOUT;
    case (state_q)
      S_FETCH: begin
        req_r = 1'b1;
        b_r   = ALU_SRC_B_FOUR;
        res_r = RESULT_SRC_ALU;
        irw_r = mem_ready;
        pcw_r = mem_ready;
        // A ready response on the timeout cycle still completes the fetch.
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_FAULT;
      end
      S_DECODE: begin
        a_r = ALU_SRC_A_OLDPC;
        b_r = ALU_SRC_B_IMM;
        case (opcode)
          OPCODE_LOAD, OPCODE_STORE: state_d = S_MEM_ADDR;
          OPCODE_RTYPE:              state_d = S_EXEC_R;
          OPCODE_IMM:                state_d = S_EXEC_I;
          OPCODE_LUI:                state_d = S_EXEC_LUI;
          OPCODE_BRANCH:             state_d = S_BRANCH;
          default:                   state_d = S_FAULT;
        endcase
      end
      S_MEM_ADDR: begin
        a_r = ALU_SRC_A_RS1;
        b_r = ALU_SRC_B_IMM;
        if (opcode == OPCODE_LOAD)       state_d = S_MEM_READ;
        else if (opcode == OPCODE_STORE) state_d = S_MEM_WRITE;
        else                             state_d = S_FAULT;
      end
      S_MEM_WRITE: begin
        req_r = 1'b1;
        we_r  = 1'b1;
        adr_r = 1'b1;
        if (mem_ready)    state_d = S_FETCH;
        else if (timeout) state_d = S_FAULT;
      end
      S_EXEC_R: begin
        a_r     = ALU_SRC_A_RS1;
        op_r    = ALU_OP_TYPE_R_I;
        state_d = S_WB_R;
      end
      S_WB_R: begin
        rw_r    = 1'b1;
        state_d = S_FETCH;
      end
      S_EXEC_I: begin
        a_r     = ALU_SRC_A_RS1;
        b_r     = ALU_SRC_B_IMM;
        op_r    = ALU_OP_TYPE_R_I;
        state_d = S_WB_I;
      end
      S_WB_I: begin
        rw_r    = 1'b1;
        state_d = S_FETCH;
      end
      S_MEM_READ: begin
        req_r = 1'b1;
        adr_r = 1'b1;
        if (mem_ready)    state_d = S_WB_MEM;
        else if (timeout) state_d = S_FAULT;
      end
      S_WB_MEM: begin
        rw_r    = 1'b1;
        res_r   = RESULT_SRC_RDATA;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        a_r     = ALU_SRC_A_RS1;
        op_r    = ALU_OP_TYPE_BR;
        pcw_r   = branch_taken;
        state_d = S_FETCH;
      end
      S_EXEC_LUI: begin
        b_r     = ALU_SRC_B_IMM;
        op_r    = ALU_OP_TYPE_LUI;
        state_d = S_WB_I;
      end
      S_FAULT: begin
        flt_r   = 1'b1;
        state_d = S_FAULT;
      end
      default: state_d = S_FAULT;
    endcase
  end

  // While rst is held every enable and select is forced low, even before the
  // state register has been pulled back to FETCH.
  assign mem_req    = req_r & ~rst;
  assign mem_we     = we_r  & ~rst;
  assign adr_src    = adr_r & ~rst;
  assign ir_write   = irw_r & ~rst;
  assign pc_write   = pcw_r & ~rst;
  assign reg_write  = rw_r  & ~rst;
  assign fault      = flt_r & ~rst;
  assign alu_src_a  = rst ? 2'b00 : a_r;
  assign alu_src_b  = rst ? 2'b00 : b_r;
  assign alu_op     = rst ? 2'b00 : op_r;
  assign result_src = rst ? 2'b00 : res_r;
  assign imm_type   = imm_type_of(opcode);
  assign state_o    = state_q;

`ifdef SIGMA_PERF_CNT_EN
  logic [PERF_W-1:0] cycle_q, instret_q;
  logic              retire;

  assign retire = (state_d == S_FETCH) &&
                  (state_q inside {S_MEM_WRITE, S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH});

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state_q != S_FAULT) cycle_q   <= cycle_q + 1'b1;
      if (retire)             instret_q <= instret_q + 1'b1;
    end
  end

  assign cycle_cnt_o = cycle_q;
  assign instret_o   = instret_q;
`endif

endmodule

// File: tb/tb_sigma_mc_ctrl_fsm.sv
module tb_sigma_mc_ctrl_fsm;

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IM  = 7'b0010011;
  localparam logic [6:0] LU  = 7'b0110111;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] ILL = 7'b1111111;
  localparam logic [6:0] JAL = 7'b1101111;

  logic clk = 1'b0;
  logic rst, mem_ready, branch_taken;
  logic [6:0] opcode;
  logic mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, fault;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic [2:0] imm_type;
  logic [3:0] state_o;
`ifdef SIGMA_PERF_CNT_EN
  logic [31:0] cycle_cnt_o, instret_o;
`endif

  always #5 clk = ~clk;

  sigma_mc_ctrl_fsm #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_we(mem_we),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .result_src(result_src), .imm_type(imm_type),
    .fault(fault), .state_o(state_o)
`ifdef SIGMA_PERF_CNT_EN
    , .cycle_cnt_o(cycle_cnt_o), .instret_o(instret_o)
`endif
  );

  typedef struct packed {
    logic [3:0] st;
    logic       req, we, adr, irw, pcw, rw;
    logic [1:0] a, b, op, res;
    logic [2:0] imm;
    logic       flt;
  } out_t;

  typedef struct packed {
    logic       r;
    logic [6:0] opc;
    logic       rdy;
    logic       tk;
    out_t       o;
  } step_t;

  typedef struct {
    logic [6:0]      opc;
    logic            tk;
    int              len;
    logic [0:4][3:0] st;
    logic [4:0]      rw;
    logic [4:0]      pcw;
  } vec_t;

  step_t q[$];
  vec_t  vecs[7];
  int    errors = 0;
  int    checks = 0;

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] opc);
    if (opc == LD || opc == IM) return 3'b001;
    if (opc == ST) return 3'b010;
    if (opc == BR) return 3'b011;
    if (opc == LU) return 3'b100;
    return 3'b000;
  endfunction

  // Expected controls for one cycle spent in a given state.
  function automatic out_t row(input logic [3:0] st, input logic [6:0] opc,
                               input logic rdy, input logic tk);
    out_t o = '0;
    o.st  = st;
    o.imm = imm_of(opc);
    case (st)
      4'd0:  begin o.req = 1; o.b = 2; o.res = 2; o.irw = rdy; o.pcw = rdy; end
      4'd1:  begin o.a = 1; o.b = 1; end
      4'd2:  begin o.a = 2; o.b = 1; end
      4'd3:  begin o.req = 1; o.we = 1; o.adr = 1; end
      4'd4:  begin o.a = 2; o.op = 2; end
      4'd5:  o.rw = 1;
      4'd6:  begin o.a = 2; o.b = 1; o.op = 2; end
      4'd7:  o.rw = 1;
      4'd8:  begin o.req = 1; o.adr = 1; end
      4'd9:  begin o.rw = 1; o.res = 1; end
      4'd10: begin o.a = 2; o.op = 3; o.pcw = tk; end
      4'd11: begin o.b = 1; o.op = 1; end
      4'd15: o.flt = 1;
      default: o = '0;
    endcase
    return o;
  endfunction

  task automatic ph(input logic [6:0] opc, input logic [3:0] st,
                    input logic rdy, input logic tk);
    step_t s;
    s.r = 1'b0; s.opc = opc; s.rdy = rdy; s.tk = tk;
    s.o = row(st, opc, rdy, tk);
    q.push_back(s);
  endtask

  // A reset cycle: the state register still shows where it was.
  task automatic rs(input logic [6:0] opc, input logic [3:0] cur);
    step_t s;
    s.r = 1'b1; s.opc = opc; s.rdy = rnd(); s.tk = rnd();
    s.o = '0; s.o.st = cur; s.o.imm = imm_of(opc);
    q.push_back(s);
  endtask

  // Whole-instruction path from its class and the number of wait cycles.
  task automatic push_instr(input logic [6:0] opc, input int wf, input int wm,
                            input logic tk);
    for (int i = 0; i < wf; i++) ph(opc, 4'd0, 1'b0, rnd());
    ph(opc, 4'd0, 1'b1, rnd());
    ph(opc, 4'd1, rnd(), rnd());
    case (opc)
      LD: begin
        ph(opc, 4'd2, rnd(), rnd());
        for (int i = 0; i < wm; i++) ph(opc, 4'd8, 1'b0, rnd());
        ph(opc, 4'd8, 1'b1, rnd());
        ph(opc, 4'd9, rnd(), rnd());
      end
      ST: begin
        ph(opc, 4'd2, rnd(), rnd());
        for (int i = 0; i < wm; i++) ph(opc, 4'd3, 1'b0, rnd());
        ph(opc, 4'd3, 1'b1, rnd());
      end
      RT: begin ph(opc, 4'd4, rnd(), rnd()); ph(opc, 4'd5, rnd(), rnd()); end
      IM: begin ph(opc, 4'd6, rnd(), rnd()); ph(opc, 4'd7, rnd(), rnd()); end
      LU: begin ph(opc, 4'd11, rnd(), rnd()); ph(opc, 4'd7, rnd(), rnd()); end
      BR: ph(opc, 4'd10, rnd(), tk);
      default: for (int i = 0; i < 3; i++) ph(opc, 4'd15, rnd(), rnd());
    endcase
  endtask

  task automatic run_q(input string tag);
    step_t s;
    out_t  act;
    int    idx = 0;
    while (q.size() > 0) begin
      s = q.pop_front();
      rst = s.r; opcode = s.opc; mem_ready = s.rdy; branch_taken = s.tk;
      @(negedge clk);
      act = {state_o, mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
             alu_src_a, alu_src_b, alu_op, result_src, imm_type, fault};
      checks++;
      if (act !== s.o) begin
        errors++;
        $display("FAIL %s step %0d: got %h required %h", tag, idx, act, s.o);
      end
      idx++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] legal [6];
    logic [6:0] opc;
    logic [2:0] got;

    legal = '{LD, ST, RT, IM, LU, BR};
    vecs[0] = '{RT, 1'b0, 4, {4'd0, 4'd1, 4'd4,  4'd5, 4'd0}, 5'b01000, 5'b00001};
    vecs[1] = '{IM, 1'b0, 4, {4'd0, 4'd1, 4'd6,  4'd7, 4'd0}, 5'b01000, 5'b00001};
    vecs[2] = '{LU, 1'b0, 4, {4'd0, 4'd1, 4'd11, 4'd7, 4'd0}, 5'b01000, 5'b00001};
    vecs[3] = '{LD, 1'b0, 5, {4'd0, 4'd1, 4'd2,  4'd8, 4'd9}, 5'b10000, 5'b00001};
    vecs[4] = '{ST, 1'b0, 4, {4'd0, 4'd1, 4'd2,  4'd3, 4'd0}, 5'b00000, 5'b00001};
    vecs[5] = '{BR, 1'b1, 3, {4'd0, 4'd1, 4'd10, 4'd0, 4'd0}, 5'b00000, 5'b00101};
    vecs[6] = '{BR, 1'b0, 3, {4'd0, 4'd1, 4'd10, 4'd0, 4'd0}, 5'b00000, 5'b00001};

    rst = 1'b1; opcode = RT; mem_ready = 1'b0; branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rs(RT, 4'd0); rs(BR, 4'd0);
    run_q("reset");

    // Zero-wait state paths per instruction class.
    for (int v = 0; v < 7; v++) begin
      for (int c = 0; c < vecs[v].len; c++) begin
        rst = 1'b0; opcode = vecs[v].opc; mem_ready = 1'b1;
        branch_taken = vecs[v].tk;
        @(negedge clk);
        checks++;
        if ({state_o, reg_write, pc_write} !==
            {vecs[v].st[c], vecs[v].rw[c], vecs[v].pcw[c]}) begin
          errors++;
          $display("FAIL vec%0d cycle %0d: state/rw/pcw got %h/%b/%b required %h/%b/%b",
                   v, c, state_o, reg_write, pc_write,
                   vecs[v].st[c], vecs[v].rw[c], vecs[v].pcw[c]);
        end
        @(posedge clk);
        #1;
      end
    end

    got = imm_type;
    checks++;
    if (got !== 3'b011) begin
      errors++;
      $display("FAIL beq_imm_type: got %b required 011", got);
    end

    push_instr(LD, 0, 3, 1'b0);
    run_q("lw_wait3");

    push_instr(BR, 0, 0, 1'b1);
    push_instr(BR, 0, 0, 1'b0);
    run_q("beq");

    // Illegal opcode: trap, hold 20 cycles, reset, resume.
    ph(ILL, 4'd0, 1'b1, rnd());
    ph(ILL, 4'd1, rnd(), rnd());
    for (int i = 0; i < 20; i++) ph(ILL, 4'd15, rnd(), rnd());
    rs(ILL, 4'd15);
    push_instr(RT, 0, 0, 1'b0);
    run_q("illegal");

    ph(JAL, 4'd0, 1'b1, rnd());
    ph(JAL, 4'd1, rnd(), rnd());
    ph(JAL, 4'd15, rnd(), rnd());
    rs(JAL, 4'd15);
    run_q("jal_reserved");

    // Fetch timeout: 4th unanswered cycle traps.
    for (int i = 0; i < 4; i++) ph(IM, 4'd0, 1'b0, rnd());
    for (int i = 0; i < 3; i++) ph(IM, 4'd15, rnd(), rnd());
    rs(IM, 4'd15);
    run_q("fetch_timeout");

    // Ready arriving on the 4th cycle wins over the timeout.
    push_instr(RT, 3, 0, 1'b0);
    push_instr(ST, 3, 3, 1'b0);
    run_q("ready_on_limit");

    // Store timeout.
    ph(ST, 4'd0, 1'b1, rnd());
    ph(ST, 4'd1, rnd(), rnd());
    ph(ST, 4'd2, rnd(), rnd());
    for (int i = 0; i < 4; i++) ph(ST, 4'd3, 1'b0, rnd());
    ph(ST, 4'd15, rnd(), rnd());
    rs(ST, 4'd15);
    run_q("store_timeout");

    // Reset in the middle of a load abandons the access.
    ph(LD, 4'd0, 1'b1, rnd());
    ph(LD, 4'd1, rnd(), rnd());
    ph(LD, 4'd2, rnd(), rnd());
    ph(LD, 4'd8, 1'b0, rnd());
    ph(LD, 4'd8, 1'b0, rnd());
    rs(LD, 4'd8);
    push_instr(IM, 0, 0, 1'b0);
    push_instr(LD, 3, 3, 1'b0);
    run_q("mid_reset");

    for (int n = 0; n < 40; n++) begin
      opc = legal[$urandom_range(0, 5)];
      push_instr(opc, $urandom_range(0, 3), $urandom_range(0, 3), rnd());
    end
    run_q("random");

`ifdef SIGMA_PERF_CNT_EN
    rs(RT, 4'd0);
    push_instr(RT, 0, 0, 1'b0);
    push_instr(IM, 0, 0, 1'b0);
    push_instr(ST, 0, 0, 1'b0);
    push_instr(BR, 0, 0, 1'b1);
    run_q("perf_seq");
    checks++;
    if (instret_o !== 32'd4 || cycle_cnt_o !== 32'd15) begin
      errors++;
      $display("FAIL perf: instret/cycle got %0d/%0d required 4/15", instret_o, cycle_cnt_o);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
